snd_exp_dac: RTL and testbench
==============================

// Module: snd_exp_dac
// PURPOSE
//  Back end for the expansion-audio generator: takes its unsigned 7-bit mixed level (snd_vol), applies
//  master gain and a click-free mute ramp, and drives a 1st-order delta-sigma 1-bit DAC pin.
//  Runs entirely in the snd_dac_clk domain; the input arrives from m2-clocked logic and is stability-filtered.
// PARAMETERS
//  IN_W            7   width of snd_in (unsigned level)
//  RAMP_STEP_LOG   4   ramp_lvl moves one step every 2^RAMP_STEP_LOG clocks
// PORTS
//  clk        in   1      DAC clock (snd_dac_clk); all logic on posedge
//  map_rst_n  in   1      reset, synchronous, active-low
//  snd_in     in   IN_W   mixed expansion level, asynchronous to clk
//  snd_en     in   1      1 = audio on, 0 = ramp down and mute
//  vol_gain   in   4      master gain, multiplier = vol_gain+1 (1..16)
//  dac_out    out  1      delta-sigma bitstream to the audio pin
//  muted      out  1      1 while FSM is in MUTED
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-low.
//  Reset (map_rst_n==0 at posedge): every register cleared; FSM=MUTED; ramp_lvl=0; step_ctr=0; acc=0;
//   dac_out=0; muted=1. Takes priority over all other activity, including mid-ramp.
//  Input filter: s0<=snd_in each clock; s_held<=s0 only when snd_in==s0 (two equal consecutive samples),
//   else s_held holds. Toggling input never reaches s_held.
//  Datapath (registered, unsigned, no saturation needed):
//   P1: mul <= s_held*(vol_gain+1)          11 bits, max 127*16=2032
//   P2: x   <= (mul*ramp_lvl)>>4            ramp_lvl 0..16, x max 2032 (< 2048 full scale)
//   P3: {c,acc[10:0]} = acc + x; acc<=sum[10:0]; dac_out<=c. Density of ones = x/2048.
//   Latency s_held -> dac_out reflecting change: 3 clocks. vol_gain change applies immediately (no ramp).
//  Ramp FSM (states MUTED, UP, ACTIVE, DOWN); step_ctr counts RAMP_STEP_LOG bits, free-running
//   only in UP/DOWN, cleared on every state entry; "tick" = step_ctr all-ones.
//   MUTED : ramp_lvl=0; acc held at 0, dac_out=0. snd_en=1 -> UP.
//   UP    : on tick ramp_lvl++; when ramp_lvl becomes 16 -> ACTIVE. snd_en=0 -> DOWN, keeping ramp_lvl.
//   ACTIVE: ramp_lvl=16. snd_en=0 -> DOWN.
//   DOWN  : on tick ramp_lvl--; when ramp_lvl becomes 0 -> MUTED. snd_en=1 -> UP, keeping ramp_lvl.
//   Tick and state change in same clock: level update applied, then new state next clock.
//   muted is a registered output: 1 exactly in clocks where state==MUTED.
//  ramp_lvl never wraps (clamped 0..16). Full 0->16 ramp = 16*2^RAMP_STEP_LOG clocks.
// TESTING
//  1 Reset: hold map_rst_n=0 3 clocks with snd_en=1, snd_in=64 -> dac_out=0, muted=1; release ->
//    muted=0 next clock, FSM=UP.
//  2 Ramp timing (RAMP_STEP_LOG=4): snd_en 0->1 from MUTED -> ACTIVE after exactly 256 clocks,
//    ramp_lvl increments on every 16th clock.
//  3 Density: ACTIVE, snd_in=127, vol_gain=15 -> x=2032, 2032 ones per 2048 clocks;
//    snd_in=64, vol_gain=7 -> x=512, 512 ones per 2048 clocks; snd_in=0 -> dac_out constant 0.
//  4 Filter: snd_in alternating 3/60 every clock for 100 clocks after s_held=20 -> s_held stays 20;
//    snd_in steady 60 -> s_held=60 two clocks later.
//  5 Abort: drop snd_en when ramp_lvl=8 in UP -> DOWN from 8, MUTED after 128 clocks;
//    reassert snd_en in DOWN at ramp_lvl=3 -> UP from 3.
//  6 Mid-op reset: map_rst_n=0 in ACTIVE with ones-density nonzero -> next clock dac_out=0, muted=1, acc=0.

Source files
------------

// File: rtl/snd_exp_dac.sv
// snd_exp_dac: expansion-audio back end. Stability-filters the incoming level,
// applies master gain and a click-free mute ramp, then drives a first-order
// delta-sigma 1-bit DAC. Single clock domain (snd_dac_clk).
module snd_exp_dac #(
    parameter int IN_W          = 7,
    parameter int RAMP_STEP_LOG = 4
) (
    input  logic            clk,
    input  logic            map_rst_n,
    input  logic [IN_W-1:0] snd_in,
    input  logic            snd_en,
    input  logic [3:0]      vol_gain,
    output logic            dac_out,
    output logic            muted
);

    // Product width: level times a gain of at most 16.
    localparam int         MUL_W     = IN_W + 4;
    localparam logic [4:0] RAMP_FULL = 5'd16;

    typedef enum logic [1:0] {
        MUTED  = 2'd0,
        UP     = 2'd1,
        ACTIVE = 2'd2,
        DOWN   = 2'd3
    } state_t;

    state_t                   state_q;
    state_t                   state_d;
    logic [4:0]               ramp_lvl;
    logic [4:0]               ramp_d;
    logic [RAMP_STEP_LOG-1:0] step_ctr;
    logic [RAMP_STEP_LOG-1:0] step_d;
    logic                     tick;

    logic [IN_W-1:0]          s0;
    logic [IN_W-1:0]          s_held;
    logic [MUL_W-1:0]         mul_p1;
    logic [MUL_W-1:0]         x_p2;
    logic [MUL_W-1:0]         acc;
    logic [MUL_W:0]           sum_p3;

    // Level times (gain + 1); never exceeds MUL_W bits.
    function automatic logic [MUL_W-1:0] gain_mul(input logic [IN_W-1:0] lvl,
                                                  input logic [3:0]      gain);
        return MUL_W'(lvl) * (MUL_W'(gain) + MUL_W'(1));
    endfunction

    // Scale by ramp_lvl/16; ramp_lvl <= 16 keeps the result within MUL_W bits.
    function automatic logic [MUL_W-1:0] ramp_scale(input logic [MUL_W-1:0] lvl,
                                                    input logic [4:0]       ramp);
        logic [MUL_W+4:0] prod;
        prod = (MUL_W+5)'(lvl) * (MUL_W+5)'(ramp);
        return MUL_W'(prod >> 4);
    endfunction

    assign tick   = (step_ctr == '1);
    assign sum_p3 = {1'b0, acc} + {1'b0, x_p2};

    // Ramp FSM next state, clamped ramp level and step counter.
    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_lvl;
        step_d  = '0;
        case (state_q)
            MUTED: begin
                ramp_d = '0;
                if (snd_en) state_d = UP;
            end
            UP: begin
                if (tick && (ramp_lvl < RAMP_FULL)) ramp_d = ramp_lvl + 5'd1;
                if (!snd_en)                        state_d = DOWN;
                else if (ramp_d == RAMP_FULL)       state_d = ACTIVE;
            end
            ACTIVE: begin
                ramp_d = RAMP_FULL;
                if (!snd_en) state_d = DOWN;
            end
            DOWN: begin
                if (tick && (ramp_lvl != 5'd0)) ramp_d = ramp_lvl - 5'd1;
                if (snd_en)                     state_d = UP;
                else if (ramp_d == 5'd0)        state_d = MUTED;
            end
            default: begin
                state_d = MUTED;
                ramp_d  = '0;
            end
        endcase
        if (state_d != state_q)
            step_d = '0;
        else if ((state_q == UP) || (state_q == DOWN))
            step_d = step_ctr + RAMP_STEP_LOG'(1);
    end

    // Control registers: FSM state, ramp level, step counter, muted flag.
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            state_q  <= MUTED;
            ramp_lvl <= '0;
            step_ctr <= '0;
            muted    <= 1'b1;
        end else begin
            state_q  <= state_d;
            ramp_lvl <= ramp_d;
            step_ctr <= step_d;
            muted    <= (state_d == MUTED);
        end
    end

    // Datapath: input filter, gain, ramp scaling and delta-sigma integrator.
    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            s0      <= '0;
            s_held  <= '0;
            mul_p1  <= '0;
            x_p2    <= '0;
            acc     <= '0;
            dac_out <= 1'b0;
        end else begin
            // Filter: accept a value only after two equal consecutive samples
            s0 <= snd_in;
            if (snd_in == s0) s_held <= snd_in;
            // Stage 1: master gain
            mul_p1 <= gain_mul(s_held, vol_gain);
            // Stage 2: mute ramp
            x_p2 <= ramp_scale(mul_p1, ramp_lvl);
            // Stage 3: integrator carry is the output bit; parked at zero while muted
            if (state_q == MUTED) begin
                acc     <= '0;
                dac_out <= 1'b0;
            end else begin
                acc     <= sum_p3[MUL_W-1:0];
                dac_out <= sum_p3[MUL_W];
            end
        end
    end

endmodule

// File: tb/tb_snd_exp_dac.sv
// Testbench for snd_exp_dac: stimulus queues expected observations, a monitor
// process measures the DUT and compares against them.
module tb_snd_exp_dac;

    logic       clk = 1'b0;
    logic       map_rst_n;
    logic [6:0] snd_in;
    logic       snd_en;
    logic [3:0] vol_gain;
    logic       dac_out;
    logic       muted;

    always #5 clk = ~clk;

    snd_exp_dac #(.IN_W(7), .RAMP_STEP_LOG(4)) dut (
        .clk       (clk),
        .map_rst_n (map_rst_n),
        .snd_in    (snd_in),
        .snd_en    (snd_en),
        .vol_gain  (vol_gain),
        .dac_out   (dac_out),
        .muted     (muted)
    );

    localparam int K_SIG  = 0;   // sample one signal after n posedges (n<0: now)
    localparam int K_HOLD = 1;   // signal must equal exp on each of win negedges
    localparam int K_ONES = 2;   // after n posedges, count dac_out ones over win clocks
    localparam int K_CYC  = 3;   // clocks until signal==exp must equal n (limit win)

    localparam int S_MUTED = 0, S_DAC = 1, S_RAMP = 2, S_HELD = 3, S_STATE = 4, S_ACC = 5;
    localparam int ST_MUTED = 0, ST_UP = 1, ST_ACTIVE = 2, ST_DOWN = 3;

    typedef struct {
        string name;
        int    kind;
        int    sel;
        int    n;
        int    win;
        int    exp;
    } item_t;

    item_t q[$];
    bit    busy   = 1'b0;
    int    checks = 0;
    int    errors = 0;

    function automatic int probe(input int sel);
        case (sel)
            S_MUTED: return int'(muted);
            S_DAC:   return int'(dac_out);
            S_RAMP:  return int'(dut.ramp_lvl);
            S_HELD:  return int'(dut.s_held);
            S_STATE: return int'(dut.state_q);
            S_ACC:   return int'(dut.acc);
            default: return -1;
        endcase
    endfunction

    task automatic push(input string name, input int kind, input int sel,
                        input int n, input int win, input int exp);
        item_t it;
        it.name = name; it.kind = kind; it.sel = sel;
        it.n = n; it.win = win; it.exp = exp;
        q.push_back(it);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits until the monitor has drained the queue; returns 1ns after a posedge.
    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(posedge clk);
            t++;
        end while ((busy || q.size() != 0) && t < 5000);
        if (busy || q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: monitor still busy after %0d clocks, expected idle", t);
        end
        #1;
    endtask

    // Monitor: pops expectations and measures the DUT.
    initial begin : monitor
        item_t it;
        int    act;
        int    cnt;
        bit    done;
        forever begin
            while (q.size() == 0) #1;
            it   = q.pop_front();
            busy = 1'b1;
            case (it.kind)
                K_SIG: begin
                    if (it.n >= 0) begin
                        repeat (it.n) @(posedge clk);
                        @(negedge clk);
                    end
                    check(it.name, probe(it.sel), it.exp);
                end
                K_HOLD: begin
                    act = it.exp;
                    for (int i = 0; i < it.win; i++) begin
                        @(negedge clk);
                        if (probe(it.sel) != it.exp && act == it.exp) act = probe(it.sel);
                    end
                    check(it.name, act, it.exp);
                end
                K_ONES: begin
                    repeat (it.n) @(posedge clk);
                    cnt = 0;
                    for (int i = 0; i < it.win; i++) begin
                        @(negedge clk);
                        cnt += int'(dac_out);
                    end
                    check(it.name, cnt, it.exp);
                end
                default: begin
                    cnt  = 0;
                    done = 1'b0;
                    while (!done && cnt < it.win) begin
                        @(posedge clk);
                        @(negedge clk);
                        cnt++;
                        if (probe(it.sel) == it.exp) done = 1'b1;
                    end
                    if (!done) begin
                        checks++;
                        errors++;
                        $display("FAIL %s: no event within %0d clocks, expected after %0d", it.name, cnt, it.n);
                    end else begin
                        check(it.name, cnt, it.n);
                    end
                end
            endcase
            if (q.size() == 0) busy = 1'b0;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin : stim
        // Reset held three clocks with audio requested
        map_rst_n = 1'b0; snd_en = 1'b1; snd_in = 7'd64; vol_gain = 4'd0;
        push("rst_muted", K_SIG,  S_MUTED, 1,  0, 1);
        push("rst_dac",   K_HOLD, S_DAC,   0,  2, 0);
        push("rst_state", K_SIG,  S_STATE, -1, 0, ST_MUTED);
        push("rst_ramp",  K_SIG,  S_RAMP,  -1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        map_rst_n = 1'b1;
        push("rel_muted", K_SIG, S_MUTED, 1,  0, 0);
        push("rel_state", K_SIG, S_STATE, -1, 0, ST_UP);

        // Back to MUTED with audio off; must stay muted
        wait_idle();
        map_rst_n = 1'b0; snd_en = 1'b0;
        @(posedge clk);
        #1;
        map_rst_n = 1'b1;
        push("idle_muted", K_HOLD, S_MUTED, 0, 4, 1);

        // Full ramp up: step every 16 clocks, ACTIVE on the 257th edge
        wait_idle();
        snd_en = 1'b1;
        push("ramp_e16",   K_SIG, S_RAMP,  16, 0,   0);
        push("ramp_unmut", K_SIG, S_MUTED, -1, 0,   0);
        push("ramp_e17",   K_SIG, S_RAMP,  1,  0,   1);
        push("ramp_e32",   K_SIG, S_RAMP,  15, 0,   1);
        push("ramp_e33",   K_SIG, S_RAMP,  1,  0,   2);
        push("ramp_active",K_CYC, S_STATE, 224, 400, ST_ACTIVE);
        push("ramp_full",  K_SIG, S_RAMP,  -1, 0,   16);

        // Density in ACTIVE
        wait_idle();
        snd_in = 7'd127; vol_gain = 4'd15;
        push("dens_2032", K_ONES, S_DAC, 8, 2048, 2032);
        wait_idle();
        snd_in = 7'd64; vol_gain = 4'd7;
        push("dens_512", K_ONES, S_DAC, 8, 2048, 512);
        wait_idle();
        snd_in = 7'd100; vol_gain = 4'd3;
        push("dens_400", K_ONES, S_DAC, 8, 2048, 400);
        wait_idle();
        snd_in = 7'd0;
        push("dens_zero", K_ONES, S_DAC, 8, 256, 0);

        // Input filter
        wait_idle();
        snd_in = 7'd20;
        push("filt_load", K_SIG, S_HELD, 2, 0, 20);
        wait_idle();
        push("filt_toggle", K_HOLD, S_HELD, 0, 100, 20);
        for (int i = 0; i < 100; i++) begin
            snd_in = (i % 2 == 0) ? 7'd60 : 7'd3;
            @(posedge clk);
            #1;
        end
        snd_in = 7'd60;
        push("filt_wait",   K_SIG, S_HELD, 1, 0, 20);
        push("filt_steady", K_SIG, S_HELD, 1, 0, 60);

        // Full ramp down from ACTIVE
        wait_idle();
        snd_en = 1'b0;
        push("down_full", K_CYC, S_MUTED, 257, 400, 1);
        push("down_lvl",  K_SIG, S_RAMP,  -1,  0,   0);

        // Abort ramp-up at level 8
        wait_idle();
        snd_en = 1'b1;
        repeat (129) @(posedge clk);
        #1;
        snd_en = 1'b0;
        push("abort_lvl",   K_SIG, S_RAMP,  0,   0,   8);
        push("abort_up",    K_SIG, S_STATE, -1,  0,   ST_UP);
        push("abort_state", K_SIG, S_STATE, 1,   0,   ST_DOWN);
        push("abort_keep",  K_SIG, S_RAMP,  -1,  0,   8);
        push("abort_mute",  K_CYC, S_MUTED, 128, 300, 1);

        // Abort again, then re-arm during DOWN at level 3
        wait_idle();
        snd_en = 1'b1;
        repeat (129) @(posedge clk);
        #1;
        snd_en = 1'b0;
        repeat (81) @(posedge clk);
        #1;
        snd_en = 1'b1;
        push("rearm_lvl",    K_SIG, S_RAMP,  0,   0,   3);
        push("rearm_down",   K_SIG, S_STATE, -1,  0,   ST_DOWN);
        push("rearm_up",     K_SIG, S_STATE, 1,   0,   ST_UP);
        push("rearm_keep",   K_SIG, S_RAMP,  -1,  0,   3);
        push("rearm_e226",   K_SIG, S_RAMP,  15,  0,   3);
        push("rearm_e227",   K_SIG, S_RAMP,  1,   0,   4);
        push("rearm_active", K_CYC, S_STATE, 192, 400, ST_ACTIVE);

        // Mid-operation reset while the bitstream is busy
        wait_idle();
        snd_in = 7'd127; vol_gain = 4'd15;
        push("pre_rst_dens", K_ONES, S_DAC, 8, 512, 508);
        wait_idle();
        map_rst_n = 1'b0;
        push("mid_dac",   K_SIG, S_DAC,   1,  0, 0);
        push("mid_muted", K_SIG, S_MUTED, -1, 0, 1);
        push("mid_acc",   K_SIG, S_ACC,   -1, 0, 0);
        push("mid_state", K_SIG, S_STATE, -1, 0, ST_MUTED);
        push("mid_ramp",  K_SIG, S_RAMP,  -1, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        map_rst_n = 1'b1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
